// File: rtl/tag_array_ctrl_pkg.sv
// rtl/tag_array_ctrl_pkg.sv - shared L1 tag array types and geometry
package tag_array_ctrl_pkg;

   localparam int TAG_W  = 20;
   localparam int SETS   = 128;
   localparam int ADDR_W = $clog2(SETS);

   // One stored way: valid flag in the top bit, tag below it.
   typedef struct packed {
      logic             valid;
      logic [TAG_W-2:0] tag;
   } entry_t;

   typedef enum logic {
      INIT = 1'b0,
      RUN  = 1'b1
   } state_t;

endpackage

// File: rtl/tag_array_ctrl_if.sv
// rtl/tag_array_ctrl_if.sv - lookup, write, response and SRAM port bundle
interface tag_array_ctrl_if #(
   parameter int SETS  = 128,
   parameter int TAG_W = 20
);
   localparam int ADDR_W = $clog2(SETS);

   logic              req_valid;
   logic              req_ready;
   logic [ADDR_W-1:0] req_set;
   logic [TAG_W-2:0]  req_tag;

   logic              resp_valid;
   logic              resp_hit;
   logic              resp_way;
   logic              resp_multihit;
   logic              resp_victim;

   logic              wr_valid;
   logic              wr_ready;
   logic [ADDR_W-1:0] wr_set;
   logic              wr_way;
   logic              wr_inv;
   logic [TAG_W-2:0]  wr_tag;

   logic              init_done;

   logic [ADDR_W-1:0]  sram_addr;
   logic               sram_en;
   logic               sram_wmode;
   logic [1:0]         sram_wmask;
   logic [2*TAG_W-1:0] sram_wdata;
   logic [2*TAG_W-1:0] sram_rdata;

   // Controller side: serves requests, owns the SRAM port.
   modport slave (
      input  req_valid, req_set, req_tag,
      input  wr_valid, wr_set, wr_way, wr_inv, wr_tag,
      input  sram_rdata,
      output req_ready, wr_ready, init_done,
      output resp_valid, resp_hit, resp_way, resp_multihit, resp_victim,
      output sram_addr, sram_en, sram_wmode, sram_wmask, sram_wdata
   );

   // Requester side, also models the SRAM macro.
   modport master (
      output req_valid, req_set, req_tag,
      output wr_valid, wr_set, wr_way, wr_inv, wr_tag,
      output sram_rdata,
      input  req_ready, wr_ready, init_done,
      input  resp_valid, resp_hit, resp_way, resp_multihit, resp_victim,
      input  sram_addr, sram_en, sram_wmode, sram_wmask, sram_wdata
   );

endinterface

// File: rtl/tag_array_ctrl_tag_compare.sv
// rtl/tag_array_ctrl_tag_compare.sv - two-way tag match and invalid-way detect
module tag_compare #(
   parameter int TAG_W = 20
) (
   input  logic [2*TAG_W-1:0] rdata,
   input  logic [TAG_W-2:0]   tag,
   output logic               hit,
   output logic               way,
   output logic               multihit,
   output logic [1:0]         invalid
);
   import tag_array_ctrl_pkg::*;

   logic [1:0] match;

   // Per-way match against the registered lookup tag, then reduce.
   always_comb begin
      match   = '0;
      invalid = '0;
      for (int w = 0; w < 2; w++) begin
         invalid[w] = ~rdata[w*TAG_W + TAG_W-1];
         match[w]   = rdata[w*TAG_W + TAG_W-1] & (rdata[w*TAG_W +: TAG_W-1] == tag);
      end
      hit      = |match;
      way      = ~match[0] & match[1];
      multihit = &match;
   end

endmodule

// File: rtl/tag_array_ctrl.sv
// rtl/tag_array_ctrl.sv - tag SRAM owner: clear sweep, write/lookup arbitration, compare
module tag_array_ctrl #(
   parameter int SETS  = 128,
   parameter int TAG_W = 20
) (
   input  logic             clock,
   input  logic             reset_n,
   tag_array_ctrl_if.slave  bus
);
   import tag_array_ctrl_pkg::*;

   localparam int CNT_W = $clog2(SETS);

   state_t             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               rr_q, rr_d;
   logic               rv_q, rv_d;
   logic [TAG_W-2:0]   tag_q, tag_d;
   logic [TAG_W-1:0]   wr_entry;

   logic               cmp_hit;
   logic               cmp_way;
   logic               cmp_multihit;
   logic [1:0]         cmp_invalid;

   // Compare the tags returned for last cycle's lookup.
   tag_compare #(.TAG_W(TAG_W)) u_cmp (
      .rdata    (bus.sram_rdata),
      .tag      (tag_q),
      .hit      (cmp_hit),
      .way      (cmp_way),
      .multihit (cmp_multihit),
      .invalid  (cmp_invalid)
   );

   assign wr_entry = bus.wr_inv ? '0 : {1'b1, bus.wr_tag};

   // Next state, SRAM port drive and request readiness; SRAM is quiet while reset is held.
   always_comb begin
      state_d        = state_q;
      cnt_d          = cnt_q;
      rr_d           = rr_q;
      rv_d           = 1'b0;
      tag_d          = tag_q;
      bus.req_ready  = 1'b0;
      bus.wr_ready   = 1'b0;
      bus.init_done  = 1'b0;
      bus.sram_en    = 1'b0;
      bus.sram_wmode = 1'b0;
      bus.sram_wmask = 2'b00;
      bus.sram_addr  = '0;
      bus.sram_wdata = '0;
      case (state_q)
         INIT: begin
            if (reset_n) begin
               bus.sram_en    = 1'b1;
               bus.sram_wmode = 1'b1;
               bus.sram_wmask = 2'b11;
               bus.sram_addr  = cnt_q;
               cnt_d          = cnt_q + 1'b1;
               if (cnt_q == CNT_W'(SETS-1)) begin
                  state_d = RUN;
                  cnt_d   = '0;
               end
            end
         end
         RUN: begin
            bus.init_done = 1'b1;
            bus.wr_ready  = 1'b1;
            bus.req_ready = ~bus.wr_valid;
            if (bus.wr_valid) begin
               bus.sram_en    = 1'b1;
               bus.sram_wmode = 1'b1;
               bus.sram_wmask = bus.wr_way ? 2'b10 : 2'b01;
               bus.sram_addr  = bus.wr_set;
               bus.sram_wdata = {wr_entry, wr_entry};
            end else if (bus.req_valid) begin
               bus.sram_en   = 1'b1;
               bus.sram_addr = bus.req_set;
               tag_d         = bus.req_tag;
               rv_d          = 1'b1;
            end
         end
         default: state_d = INIT;
      endcase
      if (rv_q && !cmp_hit && cmp_invalid == 2'b00) begin
         rr_d = ~rr_q;
      end
   end

   // Controller state registers.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= INIT;
         cnt_q   <= '0;
         rr_q    <= 1'b0;
         rv_q    <= 1'b0;
         tag_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         rr_q    <= rr_d;
         rv_q    <= rv_d;
         tag_q   <= tag_d;
      end
   end

   assign bus.resp_valid    = rv_q;
   assign bus.resp_hit      = rv_q & cmp_hit;
   assign bus.resp_way      = rv_q & cmp_way;
   assign bus.resp_multihit = rv_q & cmp_multihit;
   assign bus.resp_victim   = rv_q & (cmp_invalid[0] ? 1'b0 : (cmp_invalid[1] ? 1'b1 : rr_q));

endmodule

// File: tb/tb_tag_array_ctrl.sv
// tb/tb_tag_array_ctrl.sv - scoreboard bench for tag_array_ctrl
module tb_tag_array_ctrl;
   import tag_array_ctrl_pkg::*;

   typedef struct {
      int   due;
      logic hit;
      logic way;
      logic multi;
      logic victim;
   } resp_t;

   logic clock   = 1'b0;
   logic reset_n = 1'b0;
   int   n_cmp   = 0;
   int   n_err   = 0;
   int   cyc     = 0;

   entry_t exp_mem [SETS][2];
   logic   exp_rr;
   resp_t  sb_q [$];
   resp_t  mon_r;
   logic [2*TAG_W-1:0] sram_mem [SETS];

   always #5 clock = ~clock;

   tag_array_ctrl_if #(.SETS(SETS), .TAG_W(TAG_W)) bus ();

   tag_array_ctrl #(.SETS(SETS), .TAG_W(TAG_W)) dut (
      .clock   (clock),
      .reset_n (reset_n),
      .bus     (bus)
   );

   always @(posedge clock) cyc <= cyc + 1;

   // Behavioural single-port SRAM with registered read data.
   always @(posedge clock) begin
      if (bus.sram_en) begin
         if (bus.sram_wmode) begin
            if (bus.sram_wmask[0]) sram_mem[bus.sram_addr][TAG_W-1:0]       <= bus.sram_wdata[TAG_W-1:0];
            if (bus.sram_wmask[1]) sram_mem[bus.sram_addr][2*TAG_W-1:TAG_W] <= bus.sram_wdata[2*TAG_W-1:TAG_W];
         end else begin
            bus.sram_rdata <= sram_mem[bus.sram_addr];
         end
      end
   end

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   // Pop and compare every response the DUT produces; flag late or missing ones.
   always @(negedge clock) begin
      if (reset_n) begin
         if (bus.resp_valid) begin
            if (sb_q.size() == 0) begin
               chk("resp_unexpected", 1, 0);
            end else begin
               mon_r = sb_q.pop_front();
               chk("resp_cycle",    cyc,               mon_r.due);
               chk("resp_hit",      bus.resp_hit,      mon_r.hit);
               chk("resp_way",      bus.resp_way,      mon_r.way);
               chk("resp_multihit", bus.resp_multihit, mon_r.multi);
               chk("resp_victim",   bus.resp_victim,   mon_r.victim);
            end
         end else if (sb_q.size() > 0 && sb_q[0].due <= cyc) begin
            chk("resp_missing", 0, 1);
            void'(sb_q.pop_front());
         end
      end
   end

   task automatic model_lookup(input int rset, input int rtag);
      resp_t  r;
      entry_t e0, e1;
      logic   m0, m1;
      e0 = exp_mem[rset][0];
      e1 = exp_mem[rset][1];
      m0 = e0.valid && (e0.tag == (TAG_W-1)'(rtag));
      m1 = e1.valid && (e1.tag == (TAG_W-1)'(rtag));
      r.due    = cyc + 1;
      r.hit    = m0 | m1;
      r.way    = !m0 && m1;
      r.multi  = m0 && m1;
      r.victim = !e0.valid ? 1'b0 : (!e1.valid ? 1'b1 : exp_rr);
      if (!r.hit && e0.valid && e1.valid) exp_rr = ~exp_rr;
      sb_q.push_back(r);
   endtask

   task automatic step(input bit wv, input int wset, input bit wway, input bit winv, input int wtag,
                       input bit rv, input int rset, input int rtag);
      entry_t e;
      @(negedge clock);
      bus.wr_valid  = wv;
      bus.wr_set    = ADDR_W'(wset);
      bus.wr_way    = wway;
      bus.wr_inv    = winv;
      bus.wr_tag    = (TAG_W-1)'(wtag);
      bus.req_valid = rv;
      bus.req_set   = ADDR_W'(rset);
      bus.req_tag   = (TAG_W-1)'(rtag);
      #1;
      chk("wr_ready",  bus.wr_ready,  1);
      chk("req_ready", bus.req_ready, !wv);
      if (rv && !wv) model_lookup(rset, rtag);
      if (wv) begin
         e.valid = !winv;
         e.tag   = winv ? '0 : (TAG_W-1)'(wtag);
         exp_mem[wset][wway] = e;
      end
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_ctl"}, {bus.req_ready, bus.wr_ready, bus.resp_valid, bus.resp_hit, bus.resp_way,
                          bus.resp_multihit, bus.resp_victim, bus.init_done, bus.sram_en,
                          bus.sram_wmode, bus.sram_wmask}, 0);
      chk({tag, "_addr"},  bus.sram_addr,  0);
      chk({tag, "_wdata"}, bus.sram_wdata, 0);
   endtask

   // Release reset and follow the clear sweep cycle by cycle.
   task automatic release_and_sweep();
      @(negedge clock);
      reset_n = 1'b1;
      for (int i = 0; i < SETS; i++) begin
         if (i > 0) @(negedge clock);
         #1;
         chk("sweep_ctl", {bus.sram_en, bus.sram_wmode, bus.sram_wmask, bus.sram_addr,
                           bus.req_ready, bus.wr_ready, bus.init_done},
                          {1'b1, 1'b1, 2'b11, ADDR_W'(i), 3'b000});
         chk("sweep_wdata", bus.sram_wdata, 0);
      end
      @(negedge clock);
      #1;
      chk("init_done", {bus.init_done, bus.wr_ready, bus.req_ready, bus.sram_en}, 4'b1110);
      for (int s = 0; s < SETS; s++) begin
         exp_mem[s][0] = '0;
         exp_mem[s][1] = '0;
      end
      exp_rr = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      bus.req_valid = 0; bus.req_set = '0; bus.req_tag = '0;
      bus.wr_valid  = 0; bus.wr_set  = '0; bus.wr_way  = 0; bus.wr_inv = 0; bus.wr_tag = '0;
      exp_rr = 1'b0;
      repeat (3) @(negedge clock);
      #1;
      check_reset_outputs("reset");
      release_and_sweep();

      // Refill set 5 way 1, look it up.
      step(1, 5, 1, 0, 'h1234, 0, 0, 0);
      step(0, 0, 0, 0, 0,      1, 5, 'h1234);
      // Fill set 9, then three back-to-back misses rotate the victim.
      step(1, 9, 0, 0, 'h1, 0, 0, 0);
      step(1, 9, 1, 0, 'h2, 0, 0, 0);
      step(0, 0, 0, 0, 0, 1, 9, 'h3);
      step(0, 0, 0, 0, 0, 1, 9, 'h3);
      step(0, 0, 0, 0, 0, 1, 9, 'h3);
      // Write wins over a held lookup for four cycles.
      for (int i = 0; i < 4; i++) step(1, 20 + i, 0, 0, 'h55, 1, 20, 'h55);
      step(0, 0, 0, 0, 0, 1, 20, 'h55);
      // Duplicate tag in both ways, then invalidate way 0.
      step(1, 3, 0, 0, 'h7, 0, 0, 0);
      step(1, 3, 1, 0, 'h7, 0, 0, 0);
      step(0, 0, 0, 0, 0, 1, 3, 'h7);
      step(1, 3, 0, 1, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0, 1, 3, 'h7);
      // Write right after a lookup of the same set does not disturb it.
      step(0, 0, 0, 0, 0, 1, 9, 'h1);
      step(1, 9, 0, 1, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0, 1, 9, 'h1);
      // Mixed random traffic on a few sets.
      for (int i = 0; i < 60; i++) begin
         step($urandom_range(0, 2) == 0, $urandom_range(0, 3), $urandom_range(0, 1),
              $urandom_range(0, 3) == 0, $urandom_range(1, 3),
              $urandom_range(0, 1) == 1, $urandom_range(0, 3), $urandom_range(1, 3));
      end
      idle(3);
      chk("sb_drain", sb_q.size(), 0);

      // Reset right after a lookup is accepted suppresses its response.
      step(0, 0, 0, 0, 0, 1, 5, 'h1234);
      bus.req_valid = 0;
      @(posedge clock);
      #2;
      reset_n = 1'b0;
      #1;
      sb_q.delete();
      check_reset_outputs("rst_lookup");
      // Reset again part way through the sweep.
      @(negedge clock);
      reset_n = 1'b1;
      repeat (60) @(posedge clock);
      #2;
      reset_n = 1'b0;
      #1;
      check_reset_outputs("rst_sweep");
      release_and_sweep();
      step(0, 0, 0, 0, 0, 1, 5, 'h1234);
      idle(3);
      chk("sb_drain_end", sb_q.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/tag_array_ctrl.md
# tag_array_ctrl

Initiator-side controller for the 2-way, 128-set, 20-bit-per-way single-port tag SRAM wrapper used by the L1 cache. It owns the SRAM RW port. After reset it clears every entry. It then arbitrates between refill/invalidate writes and lookup reads, compares the read tags, and returns hit, way and victim information one cycle after each accepted lookup.

## Interface
Parameters:
- SETS, 128, number of sets; power of two; ADDR_W = log2(SETS).
- TAG_W, 20, stored entry width per way: bit TAG_W-1 is valid, bits TAG_W-2:0 are the tag.

Ports:
- clock  in  1  sole clock.
- reset_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  lookup request.
- req_ready  out  1  lookup accepted when req_valid & req_ready.
- req_set  in  ADDR_W  lookup set index.
- req_tag  in  TAG_W-1  lookup tag.
- resp_valid  out  1  one-cycle pulse with the lookup result; no backpressure.
- resp_hit  out  1  some valid way matched.
- resp_way  out  1  matching way (lowest index on multi-hit).
- resp_multihit  out  1  both ways matched (error indication).
- resp_victim  out  1  way to replace on miss.
- wr_valid  in  1  write request.
- wr_ready  out  1  write accepted when wr_valid & wr_ready.
- wr_set  in  ADDR_W  write set.
- wr_way  in  1  way to write.
- wr_inv  in  1  1 = invalidate (write all-zero entry); 0 = refill (write {1'b1, wr_tag}).
- wr_tag  in  TAG_W-1  refill tag.
- init_done  out  1  clear sweep complete.
- sram_addr  out  ADDR_W  SRAM address.
- sram_en  out  1  SRAM enable.
- sram_wmode  out  1  1 = write.
- sram_wmask  out  2  per-way write mask; bit 1 = way 1.
- sram_wdata  out  2*TAG_W  {way1, way0}.
- sram_rdata  in  2*TAG_W  {way1, way0}; valid the cycle after a read.

## Operation
- States: INIT, RUN.
- INIT: entered asynchronously on reset_n low.
  - Sweep counter starts at 0.
  - Each cycle drives sram_en=1, sram_wmode=1, sram_wmask=2'b11, sram_wdata=0, sram_addr=counter.
  - After address SETS-1 is written, the controller moves to RUN and sets init_done=1.
  - req_ready=wr_ready=0 throughout INIT.
- RUN arbitration, fixed priority write > lookup:
  - wr_ready=1 always.
  - req_ready = ~wr_valid.
  - An accepted write drives sram_wmode=1, sram_wmask = onehot(wr_way), and places the entry in both halves of sram_wdata.
  - An accepted lookup drives sram_wmode=0 and sram_addr=req_set, and registers req_tag.
  - Idle cycles drive sram_en=0.
- Compare stage (cycle after an accepted lookup):
  - match[w] = valid[w] & (tag[w] == registered tag).
  - resp_hit = |match.
  - resp_way = match[0] ? 0 : 1 when a hit occurs; 0 on miss.
  - resp_multihit = &match.
- Victim selection:
  - If a way is invalid, resp_victim is the lowest invalid way.
  - Otherwise resp_victim = rr bit.
  - rr toggles on every resp_valid with resp_hit=0 and both ways valid.
  - rr resets to 0.
- Back-to-back lookups are fully pipelined at one per cycle.
- A write to the same set in the cycle after a lookup does not affect that lookup's result, because the result reflects the pre-write contents.

## Timing
- Reset values: req_ready=0, wr_ready=0, resp_valid=0, resp_hit=0, resp_way=0, resp_multihit=0, resp_victim=0, init_done=0, sram_en=0, sram_wmode=0, sram_wmask=0, sram_addr=0, sram_wdata=0, rr=0.
- SRAM outputs are combinational from state and requests.
- Sweep: first write on the first clock edge after reset_n deasserts. Writes occupy cycles 0..SETS-1. init_done=1 and readiness begin at cycle SETS.
- Lookup latency: accepted at edge N; resp_* valid during cycle N+1, for exactly one cycle.
- Write: takes effect at the accepting edge. A lookup of that set accepted on any later edge sees the new entry.
- Simultaneous wr_valid and req_valid: the write wins and the lookup stalls with req_ready=0. No request is dropped.
- reset_n asserted mid-sweep or mid-lookup: the controller immediately returns to INIT with reset values. Any pending resp_valid is suppressed, and the sweep restarts from 0.

## Structure
- A shared cache package holds:
  - the entry typedef (valid + tag);
  - TAG_W, SETS, ADDR_W;
  - the state enum {INIT, RUN}.
- The compare/victim logic forms one natural sub-module, tag_compare (combinational match, multihit and invalid-way detection). Everything else is flat.

## Test plan
- Reset release: observe SETS=128 write cycles to addresses 0..127 with wdata=0 and wmask=2'b11. init_done rises at cycle 128, and no request is accepted earlier.
- Refill set 5 way 1 with tag 0x1234, then look up set 5 with tag 0x1234 -> next cycle resp_hit=1, resp_way=1, resp_victim=0 (way 0 invalid).
- Fill both ways of set 9 (tags 0x1, 0x2), then issue three missing lookups of tag 0x3 -> resp_victim sequence 0, 1, 0.
- Hold wr_valid and req_valid together for 4 cycles -> 4 writes issued, req_ready=0, no resp_valid. On the 5th cycle the lookup is accepted.
- Refill set 3 with both ways tag 0x7 (forced duplicate), then look up tag 0x7 -> resp_hit=1, resp_way=0, resp_multihit=1. Invalidate way 0 and repeat -> resp_way=1, resp_multihit=0.
- Assert reset_n low at sweep cycle 60 -> outputs reset; after release the sweep restarts at address 0 and init_done rises 128 cycles later.
